prbs9_source: RTL and testbench
===============================

// Module: prbs9_source
// PURPOSE
//  Pseudo-random bit source that feeds the symbol mapper's serial input (i_rbit).
//  It is a PRBS9 LFSR (x^9 + x^5 + 1) that advances one bit per symbol-rate tick.
//  The tick comes from an internal clock divider.
//  It also provides seed loading, a bit-valid strobe and a sequence-wrap strobe,
//  so downstream stages and benches can align to the 511-bit period.
// PARAMETERS
//  SEED   9'h1AA  reset and default LFSR state; must be nonzero
//  N_DIV  4       clocks per output bit; legal range 1..255
//  DIV_W  8       width of the divider counter; must hold N_DIV-1
// PORTS
//  clk          in   1  system clock, rising edge
//  i_rst_n      in   1  asynchronous reset, active-low
//  i_enable     in   1  run enable; low freezes divider, LFSR and period counter
//  i_load_seed  in   1  synchronous seed load strobe
//  i_seed       in   9  seed value, sampled when i_load_seed=1
//  o_bit        out  1  current PRBS bit (registered); held between ticks
//  o_valid      out  1  one-clock strobe: o_bit updated this cycle
//  o_wrap       out  1  one-clock strobe, coincident with o_valid of bit 511 of the period
//  o_state      out  9  current LFSR register, for debug and bench alignment
// BEHAVIOUR
//  Reset (i_rst_n=0, async):
//   - lfsr=SEED, div_cnt=0, per_cnt=0
//   - o_bit=0, o_valid=0, o_wrap=0
//   - o_state=SEED
//  Divider:
//   - While i_enable=1, div_cnt counts 0..N_DIV-1 and then wraps to 0.
//   - tick = i_enable && (div_cnt==N_DIV-1).
//   - With N_DIV=1, tick fires on every enabled clock.
//   - While i_enable=0, div_cnt holds its value and there is no tick.
//  On tick (registered, 1-clock latency):
//   - o_bit <= lfsr[8]
//   - lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]}
//   - o_valid <= 1; o_valid is 0 on every other cycle
//  Output order and period:
//   - The first 9 bits after reset or a seed load are the seed bits, MSB first.
//   - The sequence period is 511 bits. The all-zero state is never reached.
//  Period counter:
//   - per_cnt counts ticks 0..510 and wraps to 0.
//   - o_wrap <= tick && (per_cnt==510).
//   - After the wrap tick, lfsr equals the state it held at period start.
//  Seed load (i_load_seed=1, synchronous, highest priority):
//   - lfsr <= (i_seed==0) ? SEED : i_seed. A zero seed is substituted to avoid lock-up.
//   - div_cnt <= 0 and per_cnt <= 0.
//   - o_valid <= 0 and o_wrap <= 0, even if a tick would have fired that cycle.
//   - o_bit holds its value.
//   - The load is honoured whether i_enable is high or low.
//  Simultaneous events:
//   - load + tick: the load wins and the tick is dropped.
//   - i_enable falling on a tick cycle: the tick is not taken, because enable is sampled in that same cycle.
//  Reset mid-operation: all state returns to reset values immediately (async).
//   - Output resumes with the SEED MSB, N_DIV enabled clocks after reset deassertion.
//  o_state is a direct copy of the lfsr register and needs no extra register.
// TESTING
//  1. Reset check, N_DIV=4, SEED=9'h1AA:
//     - hold i_rst_n=0 -> o_bit=0, o_valid=0, o_wrap=0, o_state=9'h1AA
//  2. First bits:
//     - release reset with i_enable=1 -> o_valid pulses every 4th clock
//     - the first 9 bits are 1,1,0,1,0,1,0,1,0
//  3. Full period:
//     - run 511 ticks -> o_wrap high exactly once, on tick 511, and o_state=9'h1AA again
//     - bits 512..520 repeat bits 1..9
//     - compare the whole stream against a bench-side reference LFSR
//  4. Enable gating:
//     - drop i_enable for 7 clocks mid-divide -> no o_valid and o_state frozen
//     - the next o_valid arrives after the remaining divider count
//  5. Seed load:
//     - load i_seed=9'h001 on a tick cycle -> no o_valid that cycle
//     - the next 9 bits are 0,0,0,0,0,0,0,0,1
//     - load i_seed=0 -> o_state=9'h1AA
//  6. Async reset mid-run:
//     - assert i_rst_n=0 between clock edges -> outputs clear without waiting for a clock edge
//     - after release, the stream restarts from 1,1,0,...

Source files
------------

// File: rtl/prbs9_source.sv
// prbs9_source: PRBS9 (x^9 + x^5 + 1) bit source advancing one bit per divided tick.
// Ports:
//   clk         system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_enable    run enable; low freezes divider, LFSR and period counter
//   i_load_seed synchronous seed load strobe (highest priority)
//   i_seed      seed value, zero substituted by SEED
//   o_bit       current PRBS bit, held between ticks
//   o_valid     one-clock strobe when o_bit updates
//   o_wrap      one-clock strobe with o_valid of the last bit of the 511-bit period
//   o_state     current LFSR register
module prbs9_source #(
  parameter logic [8:0] SEED  = 9'h1AA,
  parameter int         N_DIV = 4,
  parameter int         DIV_W = 8
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_load_seed,
  input  logic [8:0] i_seed,
  output logic       o_bit,
  output logic       o_valid,
  output logic       o_wrap,
  output logic [8:0] o_state
);
  logic [8:0]       lfsr;
  logic [DIV_W-1:0] div_cnt;
  logic [8:0]       per_cnt;
  logic             tick;
  logic             last;
  assign tick    = i_enable && (div_cnt == DIV_W'(N_DIV - 1));
  assign last    = per_cnt == 9'd510;
  assign o_state = lfsr;
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr    <= SEED;
      div_cnt <= '0;
      per_cnt <= '0;
      o_bit   <= 1'b0;
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end else if (i_load_seed) begin
      // an all-zero seed would lock the LFSR, so fall back to SEED
      lfsr    <= (i_seed == 9'd0) ? SEED : i_seed;
      div_cnt <= '0;
      per_cnt <= '0;
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end else begin
      o_valid <= tick;
      o_wrap  <= tick && last;
      if (i_enable) div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        o_bit   <= lfsr[8];
        lfsr    <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        per_cnt <= last ? 9'd0 : per_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_prbs9_source.sv
// tb_prbs9_source: randomized self-checking bench for prbs9_source against a stream-recurrence model.
module tb_prbs9_source;
  localparam logic [8:0] SEED  = 9'h1AA;
  localparam int         N_DIV = 4;
  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_enable = 1'b0;
  logic       i_load_seed = 1'b0;
  logic [8:0] i_seed = 9'd0;
  logic       o_bit, o_valid, o_wrap;
  logic [8:0] o_state;
  int n_cmp = 0;
  int n_err = 0;
  bit ref_s [520];
  int en_cnt = 0;
  int idx = 0;
  int wraps = 0;
  bit ev = 0, ew = 0, eb = 0;
  bit obs_q[$];
  prbs9_source #(.SEED(SEED), .N_DIV(N_DIV), .DIV_W(8)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_load_seed(i_load_seed),
    .i_seed(i_seed), .o_bit(o_bit), .o_valid(o_valid), .o_wrap(o_wrap), .o_state(o_state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // output stream: first 9 bits are the seed MSB first, then s[n] = s[n-9] ^ s[n-5]
  task automatic gen(input logic [8:0] sd);
    for (int i = 0; i < 9; i++) ref_s[i] = sd[8-i];
    for (int i = 9; i < 520; i++) ref_s[i] = ref_s[i-9] ^ ref_s[i-5];
  endtask
  function automatic logic [8:0] win();
    logic [8:0] w;
    for (int j = 0; j < 9; j++) w[8-j] = ref_s[(idx % 511) + j];
    return w;
  endfunction
  task automatic model_reset(input logic [8:0] sd);
    gen(sd);
    en_cnt = 0;
    idx = 0;
    ev = 0;
    ew = 0;
    obs_q.delete();
  endtask
  task automatic cyc(input bit en, input bit ld, input logic [8:0] sd);
    i_enable = en;
    i_load_seed = ld;
    i_seed = sd;
    @(posedge clk);
    #1;
    if (ld) model_reset(sd == 9'd0 ? SEED : sd);
    else if (en) begin
      en_cnt++;
      ev = (en_cnt % N_DIV) == 0;
      ew = ev && (idx % 511) == 510;
      if (ev) begin
        eb = ref_s[idx % 511];
        idx++;
        wraps += int'(ew);
      end
    end else begin
      ev = 0;
      ew = 0;
    end
    chk("valid", o_valid, ev);
    chk("wrap", o_wrap, ew);
    chk("bit", o_bit, eb);
    chk("state", o_state, win());
    if (o_valid) obs_q.push_back(o_bit);
  endtask
  initial begin
    logic [8:0] first9, one9;
    first9 = 9'b110101010;
    one9 = 9'b000000001;
    model_reset(SEED);
    #12;
    chk("rst_bit", o_bit, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_wrap", o_wrap, 0);
    chk("rst_state", o_state, SEED);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    wraps = 0;
    while (idx < 511) cyc(1, 0, 9'd0);
    chk("period_wraps", wraps, 1);
    chk("period_state", o_state, SEED);
    while (idx < 520) cyc(1, 0, 9'd0);
    for (int i = 0; i < 9; i++) begin
      chk("first_bits", obs_q[i], first9[8-i]);
      chk("repeat_bits", obs_q[511+i], first9[8-i]);
    end
    while ((en_cnt % N_DIV) != 1) cyc(1, 0, 9'd0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 9'd0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 9'd0);
    while ((en_cnt % N_DIV) != N_DIV - 1) cyc(1, 0, 9'd0);
    cyc(1, 1, 9'h001);
    chk("load_tick_valid", o_valid, 0);
    while (idx < 9) cyc(1, 0, 9'd0);
    for (int i = 0; i < 9; i++) chk("seed1_bits", obs_q[i], one9[8-i]);
    cyc($urandom_range(0, 1) == 1, 1, 9'd0);
    chk("zero_seed_state", o_state, SEED);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0,
          $urandom_range(0, 3) == 0 ? 9'd0 : 9'($urandom));
    for (int i = 0; i < 10; i++) cyc(1, 0, 9'd0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_bit", o_bit, 0);
    chk("async_valid", o_valid, 0);
    chk("async_wrap", o_wrap, 0);
    chk("async_state", o_state, SEED);
    model_reset(SEED);
    eb = 0;
    #2;
    i_rst_n = 1'b1;
    while (idx < 9) cyc(1, 0, 9'd0);
    for (int i = 0; i < 9; i++) chk("restart_bits", obs_q[i], first9[8-i]);
    for (int i = 0; i < 200; i++) cyc($urandom_range(0, 3) != 0, 0, 9'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
